// File: rtl/rbm_hidden_sampler_pkg.sv
// Shared configuration for the RBM hidden-unit sampler: LFSR constants,
// FSM state encodings and packed-vector offset helpers.
package rbm_hidden_sampler_pkg;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit offset of element [r][c] in a row-major packed matrix of width-w elements.
  function automatic int elem_off(input int r, input int c, input int cols, input int w);
    return (r * cols + c) * w;
  endfunction

  // Bit offset of linear element idx in a packed vector of width-w elements.
  function automatic int lin_off(input int idx, input int w);
    return idx * w;
  endfunction

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/rbm_lfsr16.sv
// 16-bit Galois LFSR (mask 16'hB400) that advances only while en is high.
import rbm_hidden_sampler_pkg::*;

module rbm_lfsr16 #(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next state: hold unless enabled.
  always_comb begin
    state_d = state_q;
    if (en) state_d = lfsr_step(state_q);
  end

  // State register, reloads the seed on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/rbm_hidden_sampler.sv
// RBM hidden-unit sampler: bias add, hard-sigmoid and Bernoulli draw, one
// element per clock. Define RBM_PROB_OUT_EN to also expose the per-element
// clamped probabilities on prob_o.
import rbm_hidden_sampler_pkg::*;

module rbm_hidden_sampler #(
  parameter int          ROWS   = 4,
  parameter int          COLS   = 3,
  parameter int          BITLEN = 8,
  parameter int          FRAC   = 4,
  parameter logic [15:0] SEED   = LFSR_DEFAULT_SEED
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*COLS*BITLEN-1:0]   prod_i,
  input  logic [COLS*BITLEN-1:0]        bias_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROWS*COLS-1:0]          sample_o
`ifdef RBM_PROB_OUT_EN
  ,
  output logic [ROWS*COLS*FRAC-1:0]     prob_o
`endif
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic signed [BITLEN+1:0] P_HALF    = (BITLEN+2)'(1 << (FRAC - 1));
  localparam logic signed [BITLEN+1:0] P_ONE     = (BITLEN+2)'(1 << FRAC);
  localparam logic [15:0]              RAND_MASK = 16'((1 << FRAC) - 1);

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [COL_W-1:0]            col_q, col_d;
  logic [N*BITLEN-1:0]         prod_q, prod_d;
  logic [COLS*BITLEN-1:0]      bias_q, bias_d;
  logic [N-1:0]                sample_q, sample_d;
`ifdef RBM_PROB_OUT_EN
  logic [N*FRAC-1:0]           prob_q, prob_d;
`endif

  logic [15:0]                 lfsr_state;
  logic                        lfsr_en;

  logic signed [BITLEN-1:0]    elem;
  logic signed [BITLEN-1:0]    bias_e;
  logic signed [BITLEN:0]      x;
  logic signed [BITLEN:0]      x_sh;
  logic signed [BITLEN+1:0]    p_full;
  logic [FRAC-1:0]             prob;
  logic                        sample_bit;

  rbm_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (lfsr_en),
    .state_o (lfsr_state)
  );

  // Datapath for the current element: bias add, 0.25x+0.5, clamp, compare.
  always_comb begin
    elem   = prod_q[lin_off(int'(idx_q), BITLEN) +: BITLEN];
    bias_e = bias_q[elem_off(0, int'(col_q), COLS, BITLEN) +: BITLEN];
    x      = {elem[BITLEN-1], elem} + {bias_e[BITLEN-1], bias_e};
    x_sh   = x >>> 2;
    p_full = {x_sh[BITLEN], x_sh} + P_HALF;
    if (p_full[BITLEN+1])     prob = '0;
    else if (p_full >= P_ONE) prob = '1;
    else                      prob = p_full[FRAC-1:0];
    // Only the low FRAC bits of the LFSR survive the mask.
    sample_bit = (lfsr_state & RAND_MASK) < 16'(prob);
  end

  // Next-state and register updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    col_d    = col_q;
    prod_d   = prod_q;
    bias_d   = bias_q;
    sample_d = sample_q;
`ifdef RBM_PROB_OUT_EN
    prob_d   = prob_q;
`endif
    lfsr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          prod_d  = prod_i;
          bias_d  = bias_i;
          idx_d   = '0;
          col_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        lfsr_en         = 1'b1;
        sample_d[idx_q] = sample_bit;
`ifdef RBM_PROB_OUT_EN
        prob_d[lin_off(int'(idx_q), FRAC) +: FRAC] = prob;
`endif
        if (idx_q == IDX_W'(N - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
          col_d = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      col_q    <= '0;
      prod_q   <= '0;
      bias_q   <= '0;
      sample_q <= '0;
`ifdef RBM_PROB_OUT_EN
      prob_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      col_q    <= col_d;
      prod_q   <= prod_d;
      bias_q   <= bias_d;
      sample_q <= sample_d;
`ifdef RBM_PROB_OUT_EN
      prob_q   <= prob_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sample_o  = sample_q;
`ifdef RBM_PROB_OUT_EN
  assign prob_o    = prob_q;
`endif

endmodule
